// File: rtl/sfx_player_pkg.sv
// Shared definitions for the sound-effect voices: state encoding and
// helpers for deriving oscillator periods from the audio clock.
package sfx_player_pkg;

  typedef enum logic {
    SFX_IDLE = 1'b0,
    SFX_PLAY = 1'b1
  } sfx_state_t;

  localparam int unsigned AUDIO_CLK_FREQ = 50_000_000;

  // Full square-wave period in audio clock cycles for a tone of freq Hz.
  function automatic int unsigned freq_to_period(input int unsigned freq);
    return (freq == 0) ? 0 : AUDIO_CLK_FREQ / freq;
  endfunction

endpackage

// File: rtl/sfx_player_square_osc.sv
// Square-wave generator: counts phase up to the requested half period and
// flips the output bit each time it gets there.
module square_osc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [WIDTH-1:0] half_period,
  output logic             out
);

  logic [WIDTH-1:0] phase;

  // Phase counter and toggle; ">=" lets a shrinking half period toggle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      out   <= 1'b0;
    end else if (restart) begin
      phase <= '0;
      out   <= 1'b1;
    end else if (!enable) begin
      phase <= '0;
      out   <= 1'b0;
    end else if (phase >= half_period - 1'b1) begin
      phase <= '0;
      out   <= ~out;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/sfx_player.sv
// One-shot swept-tone voice: on a play strobe emits a square wave whose
// period ramps from START_PERIOD toward END_PERIOD, for a fixed duration
// or until stopped, optionally looping.
module sfx_player
  import sfx_player_pkg::*;
#(
  parameter int                    PERIOD_WIDTH    = 32,
  parameter logic [PERIOD_WIDTH-1:0] START_PERIOD    = 1_000_000,
  parameter logic [PERIOD_WIDTH-1:0] END_PERIOD      = 2_000_000,
  parameter logic [PERIOD_WIDTH-1:0] STEP            = 1000,
  parameter logic [PERIOD_WIDTH-1:0] SWEEP_CYCLES    = 100_000,
  parameter logic [PERIOD_WIDTH-1:0] DURATION_CYCLES = 50_000_000,
  parameter bit                    LOOP            = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic play,
  input  logic stop,
  output logic active,
  output logic out
);

  localparam logic [PERIOD_WIDTH-1:0] ONE        = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_WIDTH-1:0] SWEEP_LAST = SWEEP_CYCLES - ONE;
  localparam logic [PERIOD_WIDTH-1:0] DUR_LAST   = DURATION_CYCLES - ONE;
  localparam bit                      SWEEP_UP   = (END_PERIOD >= START_PERIOD);

  sfx_state_t              state;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] sweep_cnt;
  logic [PERIOD_WIDTH-1:0] dur_cnt;
  logic [PERIOD_WIDTH-1:0] half_raw;
  logic [PERIOD_WIDTH-1:0] half_period;
  logic                    end_hit;
  logic                    restart;
  logic                    go_idle;
  logic                    osc_enable;

  // Move the period one STEP toward END_PERIOD, computed one bit wider so
  // the addition or the comparison can never wrap before saturating.
  function automatic logic [PERIOD_WIDTH-1:0] step_toward(input logic [PERIOD_WIDTH-1:0] cur);
    logic [PERIOD_WIDTH:0]   wide;
    logic [PERIOD_WIDTH-1:0] result;
    if (SWEEP_UP) begin
      wide   = {1'b0, cur} + {1'b0, STEP};
      result = (wide >= {1'b0, END_PERIOD}) ? END_PERIOD : wide[PERIOD_WIDTH-1:0];
    end else begin
      wide   = {1'b0, END_PERIOD} + {1'b0, STEP};
      result = ({1'b0, cur} <= wide) ? END_PERIOD : cur - STEP;
    end
    return result;
  endfunction

  // Half-period clamp and the restart/stop decisions shared by FSM and oscillator.
  always_comb begin
    half_raw    = period_q >> 1;
    half_period = (half_raw == '0) ? ONE : half_raw;
    end_hit     = (state == SFX_PLAY) && (DURATION_CYCLES != '0) && (dur_cnt == DUR_LAST);
    restart     = !stop && (play || (end_hit && LOOP));
    go_idle     = stop || (end_hit && !LOOP && !play);
    osc_enable  = (state == SFX_PLAY) && !go_idle;
  end

  // Voice FSM with sweep and duration counters; stop beats play, play beats the natural end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SFX_IDLE;
      period_q  <= START_PERIOD;
      sweep_cnt <= '0;
      dur_cnt   <= '0;
    end else if (stop) begin
      state <= SFX_IDLE;
    end else if (restart) begin
      state     <= SFX_PLAY;
      period_q  <= START_PERIOD;
      sweep_cnt <= '0;
      dur_cnt   <= '0;
    end else if (end_hit) begin
      state <= SFX_IDLE;
    end else if (state == SFX_PLAY) begin
      if (DURATION_CYCLES != '0) begin
        dur_cnt <= dur_cnt + ONE;
      end
      if (SWEEP_CYCLES != '0) begin
        if (sweep_cnt == SWEEP_LAST) begin
          sweep_cnt <= '0;
          period_q  <= step_toward(period_q);
        end else begin
          sweep_cnt <= sweep_cnt + ONE;
        end
      end
    end
  end

  assign active = (state == SFX_PLAY);

  square_osc #(
    .WIDTH(PERIOD_WIDTH)
  ) u_osc (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (osc_enable),
    .restart    (restart),
    .half_period(half_period),
    .out        (out)
  );

endmodule
